// File: rtl/oled_spi_sink.sv
// Receiving end of the OLED 4-wire SPI link: synchronises the pins, deserialises bytes and
// tracks the SSD1331-style column/row window to turn data bytes into addressed pixel writes.
module oled_spi_sink #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin_din,
    input  logic       pin_clk,
    input  logic       pin_cs,
    input  logic       pin_dc,
    input  logic       pin_res,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       px_write,
    output logic [6:0] px_col,
    output logic [5:0] px_row,
    output logic [7:0] px_data,
    output logic       frame_done
);

    localparam logic [6:0] COL_MAX = 7'(WIDTH - 1);
    localparam logic [5:0] ROW_MAX = 6'(HEIGHT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] COL_S = 3'd1;
    localparam logic [2:0] COL_E = 3'd2;
    localparam logic [2:0] ROW_S = 3'd3;
    localparam logic [2:0] ROW_E = 3'd4;

    function automatic logic [6:0] clamp_col(input logic [7:0] v);
        if (v > 8'(WIDTH - 1)) return COL_MAX;
        return v[6:0];
    endfunction

    function automatic logic [5:0] clamp_row(input logic [7:0] v);
        if (v > 8'(HEIGHT - 1)) return ROW_MAX;
        return v[5:0];
    endfunction

    logic [SYNC_STAGES-1:0] din_sync, clk_sync, cs_sync, dc_sync, res_sync;
    logic                   clk_prev;

    // Synchroniser stage: pins reset to their idle levels so no false edge appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_sync <= '0;
            clk_sync <= '0;
            cs_sync  <= '1;
            dc_sync  <= '0;
            res_sync <= '1;
            clk_prev <= 1'b0;
        end else begin
            din_sync <= {din_sync[SYNC_STAGES-2:0], pin_din};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], pin_clk};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], pin_cs};
            dc_sync  <= {dc_sync[SYNC_STAGES-2:0], pin_dc};
            res_sync <= {res_sync[SYNC_STAGES-2:0], pin_res};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    logic din_s, dc_s, res_s, rise, link_off;
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign res_s    = res_sync[SYNC_STAGES-1];
    assign rise     = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign link_off = cs_sync[SYNC_STAGES-1] | ~res_s;

    logic [2:0] bit_cnt_p0;
    logic [6:0] shift_p0;
    logic       vld_p0;
    logic [7:0] byte_p0;

    // Deserialiser stage: bit counter wraps 7 -> 0 on the byte-completing rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         bit_cnt_p0 <= 3'd0;
        else if (link_off) bit_cnt_p0 <= 3'd0;
        else if (rise)     bit_cnt_p0 <= bit_cnt_p0 + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rise && !link_off) shift_p0 <= {shift_p0[5:0], din_s};
    end

    assign vld_p0  = rise && !link_off && (bit_cnt_p0 == 3'd7);
    assign byte_p0 = {shift_p0, din_s};

    logic [2:0] state;
    logic [6:0] col, col_start, col_end;
    logic [5:0] row, row_start, row_end;
    logic       col_wrap, row_wrap;

    assign col_wrap = (col == col_end) || (col == COL_MAX);
    assign row_wrap = (row == row_end) || (row == ROW_MAX);

    // Parser / pixel stage: all strobes registered one cycle after the completing rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'd0;
            px_write   <= 1'b0;
            px_col     <= 7'd0;
            px_row     <= 6'd0;
            px_data    <= 8'd0;
            frame_done <= 1'b0;
            state      <= IDLE;
            col        <= 7'd0;
            col_start  <= 7'd0;
            col_end    <= COL_MAX;
            row        <= 6'd0;
            row_start  <= 6'd0;
            row_end    <= ROW_MAX;
        end else begin
            cmd_valid  <= 1'b0;
            px_write   <= 1'b0;
            frame_done <= 1'b0;
            if (!res_s) begin
                state     <= IDLE;
                col       <= 7'd0;
                col_start <= 7'd0;
                col_end   <= COL_MAX;
                row       <= 6'd0;
                row_start <= 6'd0;
                row_end   <= ROW_MAX;
            end else if (vld_p0 && !dc_s) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= byte_p0;
                case (state)
                    IDLE: begin
                        if (byte_p0 == 8'h15)      state <= COL_S;
                        else if (byte_p0 == 8'h75) state <= ROW_S;
                    end
                    COL_S: begin
                        col_start <= clamp_col(byte_p0);
                        col       <= clamp_col(byte_p0);
                        state     <= COL_E;
                    end
                    COL_E: begin
                        col_end <= clamp_col(byte_p0);
                        col     <= col_start;
                        state   <= IDLE;
                    end
                    ROW_S: begin
                        row_start <= clamp_row(byte_p0);
                        row       <= clamp_row(byte_p0);
                        state     <= ROW_E;
                    end
                    ROW_E: begin
                        row_end <= clamp_row(byte_p0);
                        row     <= row_start;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (vld_p0) begin
                state      <= IDLE;
                px_write   <= 1'b1;
                px_col     <= col;
                px_row     <= row;
                px_data    <= byte_p0;
                frame_done <= (col == col_end) && (row == row_end);
                if (col_wrap) begin
                    col <= col_start;
                    row <= row_wrap ? row_start : row + 6'd1;
                end else begin
                    col <= col + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Scoreboard bench for oled_spi_sink: stimulus pushes expected strobes, a negedge monitor
// pops and compares each cmd_valid / px_write the sink produces.
module tb_oled_spi_sink;

    // Small geometry keeps the full-frame scan short.
    localparam int W = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pin_din = 1'b0, pin_clk = 1'b0, pin_cs = 1'b1, pin_dc = 1'b0, pin_res = 1'b1;
    logic       cmd_valid, px_write, frame_done;
    logic [7:0] cmd_byte, px_data;
    logic [6:0] px_col;
    logic [5:0] px_row;

    always #5 clk = ~clk;

    oled_spi_sink #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .pin_din(pin_din), .pin_clk(pin_clk), .pin_cs(pin_cs), .pin_dc(pin_dc), .pin_res(pin_res),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .px_write(px_write), .px_col(px_col), .px_row(px_row), .px_data(px_data),
        .frame_done(frame_done)
    );

    int          tests = 0;
    int          fails = 0;
    logic [22:0] sb_q[$];
    logic [22:0] mon_act, mon_exp;

    // Entry layout: {is_px, frame_done, col[6:0], row[5:0], byte[7:0]}
    function automatic logic [22:0] exp_cmd(input logic [7:0] b);
        return {2'b00, 7'd0, 6'd0, b};
    endfunction

    function automatic logic [22:0] exp_px(input logic [6:0] c, input logic [5:0] r,
                                          input logic [7:0] d, input logic f);
        return {1'b1, f, c, r, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (cmd_valid || px_write)) begin
            tests++;
            if (cmd_valid && px_write) begin
                fails++;
                $display("FAIL strobe_overlap: cmd_valid and px_write both high at %0t", $time);
            end else begin
                if (cmd_valid) mon_act = {1'b0, frame_done, 7'd0, 6'd0, cmd_byte};
                else           mon_act = {1'b1, frame_done, px_col, px_row, px_data};
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got 0x%0h expected none", mon_act);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        fails++;
                        $display("FAIL strobe: got px=%0b fd=%0b col=%0d row=%0d byte=0x%0h expected px=%0b fd=%0b col=%0d row=%0d byte=0x%0h",
                                 mon_act[22], mon_act[21], mon_act[20:14], mon_act[13:8], mon_act[7:0],
                                 mon_exp[22], mon_exp[21], mon_exp[20:14], mon_exp[13:8], mon_exp[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            pin_din = b[i];
            pin_dc  = dc;
            clk_wait(4);
            pin_clk = 1'b1;
            clk_wait(4);
            pin_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        sb_q.push_back(exp_cmd(b));
        send_bits(b, 1'b0, 8);
    endtask

    task automatic send_px(input logic [7:0] b, input logic [6:0] c, input logic [5:0] r,
                           input logic f);
        sb_q.push_back(exp_px(c, r, b, f));
        send_bits(b, 1'b1, 8);
    endtask

    task automatic res_pulse();
        pin_res = 1'b0;
        clk_wait(4);
        pin_res = 1'b1;
        clk_wait(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk_wait(3);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_px_write", 32'(px_write), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
        chk("rst_px_data", 32'(px_data), 32'd0);
        chk("rst_px_col", 32'(px_col), 32'd0);
        chk("rst_px_row", 32'(px_row), 32'd0);
        reset = 1'b0;
        clk_wait(4);
    endtask

    initial begin
        do_reset();
        pin_cs = 1'b0;
        clk_wait(4);

        // 1: plain command byte
        send_cmd(8'hAE);

        // 2: 3x2 window at (10..12, 5..6)
        send_cmd(8'h15); send_cmd(8'd10); send_cmd(8'd12);
        send_cmd(8'h75); send_cmd(8'd5);  send_cmd(8'd6);
        send_px(8'h01, 7'd10, 6'd5, 1'b0);
        send_px(8'h02, 7'd11, 6'd5, 1'b0);
        send_px(8'h03, 7'd12, 6'd5, 1'b0);
        send_px(8'h04, 7'd10, 6'd6, 1'b0);
        send_px(8'h05, 7'd11, 6'd6, 1'b0);
        send_px(8'h06, 7'd12, 6'd6, 1'b1);

        // 3: full frame after default reset, then wrap to origin
        clk_wait(10);
        chk("sb_empty_before_reset", 32'(sb_q.size()), 32'd0);
        do_reset();
        for (int i = 0; i < W * H; i++)
            send_px(8'(i), 7'(i % W), 6'(i / W), (i == W * H - 1));
        send_px(8'hA5, 7'd0, 6'd0, 1'b0);

        // 4: partial byte discarded by cs high
        send_bits(8'hFF, 1'b0, 5);
        pin_cs = 1'b1;
        clk_wait(4);
        pin_cs = 1'b0;
        clk_wait(4);
        send_cmd(8'h3C);

        // 5: out-of-range column parameters clamp to the last column
        res_pulse();
        send_cmd(8'h15); send_cmd(8'h70); send_cmd(8'h80);
        send_px(8'hAA, 7'(W - 1), 6'd0, 1'b0);
        send_px(8'hBB, 7'(W - 1), 6'd1, 1'b0);

        // 6: data byte aborts a command, then pin_res mid-byte restores the full window
        res_pulse();
        send_cmd(8'h15);
        send_px(8'h55, 7'd0, 6'd0, 1'b0);
        send_cmd(8'h15); send_cmd(8'd3); send_cmd(8'd4);
        send_bits(8'hF0, 1'b1, 3);
        res_pulse();
        send_px(8'h11, 7'd0, 6'd0, 1'b0);
        send_px(8'h22, 7'd1, 6'd0, 1'b0);

        clk_wait(20);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
